// File: rtl/pwm_capture.sv
// PWM high-time/period meter, 3 clk edge latency (3+FILTER_LEN with PWM_CAPTURE_GLITCH_FILTER_EN);
// free-running with no backpressure: valid pulses once per completed cycle, timeout flags a dead line.
module pwm_capture #(
  parameter int W          = 32,
  parameter int TIMEOUT    = 2_000_000,
  parameter int FILTER_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W-1:0] duty_out,
  output logic [W-1:0] period_out,
  output logic         valid,
  output logic         timeout,
  output logic         locked
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [W-1:0] TO_VAL = W'(TIMEOUT);
  localparam logic [W-1:0] ONE    = W'(1);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("pwm_capture: FILTER_LEN must be at least 1");
  end
  if ((TIMEOUT < 2) || (longint'(TIMEOUT) >= ((64'd1 << W) - 64'd1))) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must lie in [2, 2**W-1)");
  end

  logic         s0_q, s1_q, prev_q;
  logic         lvl;
  logic         rise, fall;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_w_q, hi_w_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         locked_q, locked_d;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int RW = $clog2(FILTER_LEN + 1);

  logic          filt_q, filt_d;
  logic [RW-1:0] run_q, run_d;

  // run_q counts consecutive samples that disagree with the filtered level
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (s1_q != filt_q) begin
      if (run_q == RW'(FILTER_LEN - 1)) begin
        filt_d = s1_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s1_q;
`endif

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  always_comb begin
    state_d   = state_q;
    hi_w_d    = hi_w_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (rise) begin
      cnt_d = ONE;
    end else if (cnt_q < TO_VAL) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          hi_w_d  = cnt_q;
        end else if (cnt_q == TO_VAL) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      LOW: begin
        // a rise landing on the timeout cycle still completes the measurement
        if (rise) begin
          state_d   = HIGH;
          duty_d    = hi_w_q;
          period_d  = cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
        end else if (cnt_q == TO_VAL) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_w_q    <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      s0_q      <= pwm_in;
      s1_q      <= s0_q;
      prev_q    <= lvl;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_w_q    <= hi_w_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Two DUTs on one PWM line: u_long (TIMEOUT=200) and u_short (TIMEOUT=50), checked against an edge-timing scoreboard.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pwm_in = 1'b0;
  logic [31:0] duty_l, period_l, duty_s, period_s;
  logic        valid_l, timeout_l, locked_l;
  logic        valid_s, timeout_s, locked_s;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {int d; int p;} meas_t;
  meas_t q_l[$];
  meas_t q_s[$];

  // edge model state per instance: index 0 = u_long, 1 = u_short
  bit armed[2];
  int rise_c[2];
  int fall_c[2];
  int to_lim[2];

  int vcyc_l, vcyc_s, first_vcyc_s;
  bit got_first_s = 1'b0;
  int to_rise_cyc_l, to_rise_cyc_s;
  logic to_prev_l = 1'b0, to_prev_s = 1'b0;

  pwm_capture #(.W(32), .TIMEOUT(200), .FILTER_LEN(4)) u_long (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty_out(duty_l), .period_out(period_l),
    .valid(valid_l), .timeout(timeout_l), .locked(locked_l)
  );

  pwm_capture #(.W(32), .TIMEOUT(50), .FILTER_LEN(4)) u_short (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty_out(duty_s), .period_out(period_s),
    .valid(valid_s), .timeout(timeout_s), .locked(locked_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else n_pass++;
  endtask

  // A measurement completes on each rise that follows an untimed-out rise;
  // a gap longer than the limit since the last rise means the DUT timed out.
  task automatic model_edge(input logic lvl, input int c);
    meas_t m;
    for (int i = 0; i < 2; i++) begin
      if (armed[i] && ((c - rise_c[i]) > to_lim[i])) armed[i] = 1'b0;
      if (lvl) begin
        if (armed[i]) begin
          m.d = fall_c[i] - rise_c[i];
          m.p = c - rise_c[i];
          if (i == 0) q_l.push_back(m);
          else q_s.push_back(m);
        end
        rise_c[i] = c;
        armed[i]  = 1'b1;
      end else begin
        fall_c[i] = c;
      end
    end
  endtask

  task automatic seg(input logic lvl, input int len);
    if (lvl !== pwm_in) model_edge(lvl, cyc);
    pwm_in = lvl;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_duty_l"}, int'(duty_l), 0);
    chk({tag, "_period_l"}, int'(period_l), 0);
    chk({tag, "_valid_l"}, int'(valid_l), 0);
    chk({tag, "_timeout_l"}, int'(timeout_l), 0);
    chk({tag, "_locked_l"}, int'(locked_l), 0);
    chk({tag, "_duty_s"}, int'(duty_s), 0);
    chk({tag, "_period_s"}, int'(period_s), 0);
    chk({tag, "_valid_s"}, int'(valid_s), 0);
    chk({tag, "_timeout_s"}, int'(timeout_s), 0);
    chk({tag, "_locked_s"}, int'(locked_s), 0);
  endtask

  always @(negedge clk) begin
    meas_t m;
    if (!rst && valid_l) begin
      vcyc_l = cyc;
      if (q_l.size() == 0) begin
        n_chk++;
        $display("FAIL l_valid: got unexpected valid duty=%0d period=%0d, required none", duty_l, period_l);
      end else begin
        m = q_l.pop_front();
        chk("l_duty", int'(duty_l), m.d);
        chk("l_period", int'(period_l), m.p);
      end
    end
    if (!rst && valid_s) begin
      vcyc_s = cyc;
      if (!got_first_s) begin
        first_vcyc_s = cyc;
        got_first_s  = 1'b1;
      end
      if (q_s.size() == 0) begin
        n_chk++;
        $display("FAIL s_valid: got unexpected valid duty=%0d period=%0d, required none", duty_s, period_s);
      end else begin
        m = q_s.pop_front();
        chk("s_duty", int'(duty_s), m.d);
        chk("s_period", int'(period_s), m.p);
      end
    end
    if (timeout_l && !to_prev_l) to_rise_cyc_l = cyc;
    if (timeout_s && !to_prev_s) to_rise_cyc_s = cyc;
    to_prev_l = timeout_l;
    to_prev_s = timeout_s;
  end

  typedef struct {
    int d; int p; int n; int hold;
    int lk_l; int to_l; int lk_s; int to_s;
    int du_l; int pe_l; int du_s; int pe_s;
  } row_t;

  initial begin
    row_t tbl[5];
    int   row_start;
    int   lo_len;

    tbl[0] = '{3, 10, 4, 0,    1, 0, 1, 0,  3, 10, 3, 10};
    tbl[1] = '{4, 20, 3, 210,  0, 1, 0, 1,  4, 20, 4, 20};
    tbl[2] = '{4, 20, 2, 0,    1, 0, 1, 0,  4, 20, 4, 20};
    tbl[3] = '{7, 20, 3, 0,    1, 0, 1, 0,  7, 20, 7, 20};
    tbl[4] = '{15, 100, 5, 0,  1, 0, 0, 1,  15, 100, 7, 20};

    to_lim[0] = 200;
    to_lim[1] = 50;
    armed[0]  = 1'b0;
    armed[1]  = 1'b0;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // line held low from reset: never locks, never reports
    seg(1'b0, 80);
    @(negedge clk);
    chk("idle_locked_l", int'(locked_l), 0);
    chk("idle_locked_s", int'(locked_s), 0);
    chk("idle_timeout_l", int'(timeout_l), 0);
    chk("idle_timeout_s", int'(timeout_s), 0);
    @(posedge clk);
    #1;

    for (int r = 0; r < 5; r++) begin
      row_start = cyc;
      for (int k = 0; k < tbl[r].n; k++) begin
        lo_len = tbl[r].p - tbl[r].d;
        if ((k == tbl[r].n - 1) && (tbl[r].hold == 0)) lo_len = lo_len - 1;
        seg(1'b1, tbl[r].d);
        seg(1'b0, lo_len);
      end
      if (tbl[r].hold > 0) begin
        seg(1'b1, tbl[r].hold);
        seg(1'b0, 9);
      end
      @(negedge clk);
      chk($sformatf("row%0d_locked_l", r), int'(locked_l), tbl[r].lk_l);
      chk($sformatf("row%0d_timeout_l", r), int'(timeout_l), tbl[r].to_l);
      chk($sformatf("row%0d_locked_s", r), int'(locked_s), tbl[r].lk_s);
      chk($sformatf("row%0d_timeout_s", r), int'(timeout_s), tbl[r].to_s);
      chk($sformatf("row%0d_duty_l", r), int'(duty_l), tbl[r].du_l);
      chk($sformatf("row%0d_period_l", r), int'(period_l), tbl[r].pe_l);
      chk($sformatf("row%0d_duty_s", r), int'(duty_s), tbl[r].du_s);
      chk($sformatf("row%0d_period_s", r), int'(period_s), tbl[r].pe_s);
      @(posedge clk);
      #1;
      // first valid: one period after the first rise, plus 3 cycles of edge latency
      if (r == 0) chk("first_valid_latency", first_vcyc_s - row_start, 13);
      if (r == 1) begin
        chk("timeout_delay_s", to_rise_cyc_s - vcyc_s, 50);
        chk("timeout_delay_l", to_rise_cyc_l - vcyc_l, 200);
      end
    end

    // 2-cycle glitch 40 cycles into the low phase: measured as a 2/45 cycle
    seg(1'b1, 15);
    seg(1'b0, 40);
    seg(1'b1, 2);
    seg(1'b0, 43);
    seg(1'b1, 15);
    seg(1'b0, 29);
    @(negedge clk);
    chk("glitch_duty_l", int'(duty_l), 2);
    chk("glitch_period_l", int'(period_l), 45);
    chk("glitch_duty_s", int'(duty_s), 2);
    chk("glitch_period_s", int'(period_s), 45);
    @(posedge clk);
    #1;

    // reset in the middle of a high phase
    seg(1'b1, 5);
    chk("pre_rst_queue_l", q_l.size(), 0);
    chk("pre_rst_queue_s", q_s.size(), 0);
    rst = 1'b1;
    armed[0] = 1'b0;
    armed[1] = 1'b0;
    #1;
    chk_all_zero("midrst");
    seg(1'b0, 3);
    rst = 1'b0;
    got_first_s = 1'b0;
    row_start = cyc;
    for (int k = 0; k < 3; k++) begin
      seg(1'b1, 3);
      seg(1'b0, 7);
    end
    seg(1'b1, 3);
    seg(1'b0, 60);
    chk("post_rst_first_valid", first_vcyc_s - row_start, 13);
    chk("end_queue_l", q_l.size(), 0);
    chk("end_queue_s", q_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
